// File: rtl/cdc_gray_pkg.sv
// Shared helpers for the gray-pointer CDC FIFO halves: pointer code conversion and
// the isolation state type used by the destination array.
package cdc_gray_pkg;

   // Widest pointer the conversion helpers handle; callers size-cast the result.
   localparam int unsigned PtrMaxW = 32;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DRAIN    = 2'd1,
      ISOLATED = 2'd2
   } iso_state_e;

   // Binary to gray over the low 'width' bits; bits above 'width' are returned as 0.
   function automatic logic [PtrMaxW-1:0] bin2gray(input logic [PtrMaxW-1:0] bin,
                                                  input int unsigned     width);
      logic [PtrMaxW-1:0] mask;
      logic [PtrMaxW-1:0] b;
      mask = '1;
      mask = mask >> (PtrMaxW - width);
      b    = bin & mask;
      return b ^ (b >> 1);
   endfunction

   // Gray to binary over the low 'width' bits. A prefix XOR from the MSB down is
   // width-independent once the unused upper bits are forced to zero.
   function automatic logic [PtrMaxW-1:0] gray2bin(input logic [PtrMaxW-1:0] gray,
                                                  input int unsigned     width);
      logic [PtrMaxW-1:0] mask;
      logic [PtrMaxW-1:0] b;
      mask = '1;
      mask = mask >> (PtrMaxW - width);
      b    = gray & mask;
      for (int unsigned s = 1; s < PtrMaxW; s = s << 1) begin
         b = b ^ (b >> s);
      end
      return b;
   endfunction

endpackage

// File: rtl/cdc_gray_dst_chan.sv
// One destination-side channel of a gray-pointer CDC FIFO: write pointer
// synchronizer, read pointer, fill level, sticky pointer error and an optional
// one-entry output register.
module cdc_gray_dst_chan
   import cdc_gray_pkg::*;
#(
   parameter int unsigned DataWidth  = 64,
   parameter int unsigned LogDepth   = 2,
   parameter int unsigned SyncStages = 2,
   parameter int unsigned OutReg     = 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [(2**LogDepth)*DataWidth-1:0]   async_data_i,
   input  logic [LogDepth:0]                    async_wptr_i,
   output logic [LogDepth:0]                    async_rptr_o,
   output logic [DataWidth-1:0]                 data_o,
   output logic                                 valid_o,
   input  logic                                 ready_i,
   output logic [LogDepth:0]                    level_o,
   // Blocks any new delivery; an already presented valid is still held to completion.
   input  logic                                 gate_i,
   output logic                                 idle_o,
   output logic                                 ovf_err_o
);

   localparam int unsigned Depth = 2**LogDepth;
   localparam int unsigned PtrW  = LogDepth + 1;

   logic [PtrW-1:0]      sync_q [SyncStages];
   logic [PtrW-1:0]      wptr_s;
   logic [PtrW-1:0]      rptr_q;
   logic [PtrW-1:0]      rptr_inc;
   logic [PtrW-1:0]      rptr_gray_q;
   logic [PtrW-1:0]      level;
   logic                 empty;
   logic                 pop;
   logic                 ovf_q;
   logic [DataWidth-1:0] rd_data;

   // Multi-flop synchronizer on the incoming gray write pointer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < SyncStages; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= async_wptr_i;
         for (int unsigned i = 1; i < SyncStages; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // Synchronized write pointer back to binary, fill level and the storage read port.
   always_comb begin
      wptr_s   = PtrW'(gray2bin(PtrMaxW'(sync_q[SyncStages-1]), PtrW));
      level    = wptr_s - rptr_q;
      empty    = (level == '0);
      rptr_inc = rptr_q + PtrW'(1);
      rd_data  = async_data_i[rptr_q[LogDepth-1:0]*DataWidth +: DataWidth];
   end

   // Read pointer, binary for local use and registered gray for the source side.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rptr_q      <= '0;
         rptr_gray_q <= '0;
      end else if (pop) begin
         rptr_q      <= rptr_inc;
         rptr_gray_q <= PtrW'(bin2gray(PtrMaxW'(rptr_inc), PtrW));
      end
   end

   // A level beyond the depth can only come from a corrupted pointer; remember it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovf_q <= 1'b0;
      end else if (level > PtrW'(Depth)) begin
         ovf_q <= 1'b1;
      end
   end

   if (OutReg != 0) begin : g_outreg
      logic                 out_valid_q;
      logic [DataWidth-1:0] out_data_q;
      logic                 load;

      // Refill the stage whenever it is empty or being emptied this cycle.
      always_comb begin
         load = (!out_valid_q || ready_i) && !empty && !gate_i;
         pop  = load;
      end

      // Output stage: a load wins over a plain handshake so throughput stays 1/cycle.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
         end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= rd_data;
         end else if (ready_i) begin
            out_valid_q <= 1'b0;
         end
      end

      assign valid_o = out_valid_q;
      assign data_o  = out_data_q;
   end else begin : g_fallthrough
      logic pend_q;
      logic valid;

      // A presented-but-unaccepted entry stays valid even once gating starts.
      always_comb begin
         valid = !empty && (!gate_i || pend_q);
         pop   = valid && ready_i;
      end

      // Tracks a valid that is still waiting for its handshake.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            pend_q <= 1'b0;
         end else begin
            pend_q <= valid && !ready_i;
         end
      end

      assign valid_o = valid;
      assign data_o  = rd_data;
   end

   assign async_rptr_o = rptr_gray_q;
   assign level_o      = level;
   assign idle_o       = !valid_o;
   assign ovf_err_o    = ovf_q;

endmodule

// File: rtl/cdc_gray_dst_array.sv
// Destination half of a multi-channel gray-pointer CDC FIFO array. Channels are
// independent apart from a shared drain-and-isolate controller that lets the far
// clock domain be gated once every channel has quiesced.
module cdc_gray_dst_array
   import cdc_gray_pkg::*;
#(
   parameter int unsigned NumChan    = 5,
   parameter int unsigned DataWidth  = 64,
   parameter int unsigned LogDepth   = 2,
   parameter int unsigned SyncStages = 2,
   parameter int unsigned OutReg     = 1
) (
   input  logic                                         dst_clk_i,
   input  logic                                         dst_rst_i,
   input  logic [NumChan*(2**LogDepth)*DataWidth-1:0]   async_data_i,
   input  logic [NumChan*(LogDepth+1)-1:0]              async_wptr_i,
   output logic [NumChan*(LogDepth+1)-1:0]              async_rptr_o,
   output logic [NumChan*DataWidth-1:0]                 dst_data_o,
   output logic [NumChan-1:0]                           dst_valid_o,
   input  logic [NumChan-1:0]                           dst_ready_i,
   output logic [NumChan*(LogDepth+1)-1:0]              level_o,
   input  logic                                         isolate_i,
   output logic                                         isolated_o,
   output logic [NumChan-1:0]                           ovf_err_o
);

   localparam int unsigned PtrW     = LogDepth + 1;
   localparam int unsigned ChanBits = (2**LogDepth) * DataWidth;

   iso_state_e         state_q;
   logic [NumChan-1:0] gate_q;
   logic [NumChan-1:0] idle;
   logic               isolated_q;
   logic               stop;

   // Outside RUN no channel may start a new delivery.
   assign stop = (state_q != RUN);

   for (genvar c = 0; c < NumChan; c++) begin : g_chan
      cdc_gray_dst_chan #(
         .DataWidth  (DataWidth),
         .LogDepth   (LogDepth),
         .SyncStages (SyncStages),
         .OutReg     (OutReg)
      ) u_chan (
         .clk_i        (dst_clk_i),
         .rst_i        (dst_rst_i),
         .async_data_i (async_data_i[c*ChanBits +: ChanBits]),
         .async_wptr_i (async_wptr_i[c*PtrW +: PtrW]),
         .async_rptr_o (async_rptr_o[c*PtrW +: PtrW]),
         .data_o       (dst_data_o[c*DataWidth +: DataWidth]),
         .valid_o      (dst_valid_o[c]),
         .ready_i      (dst_ready_i[c]),
         .level_o      (level_o[c*PtrW +: PtrW]),
         .gate_i       (stop),
         .idle_o       (idle[c]),
         .ovf_err_o    (ovf_err_o[c])
      );
   end

   // Isolation controller: in DRAIN a channel's gate latches once it has nothing
   // presented or its pending beat is accepted; all gates latched means quiesced.
   always_ff @(posedge dst_clk_i) begin
      if (dst_rst_i) begin
         state_q    <= RUN;
         gate_q     <= '0;
         isolated_q <= 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               gate_q     <= '0;
               isolated_q <= 1'b0;
               if (isolate_i) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (!isolate_i) begin
                  state_q <= RUN;
                  gate_q  <= '0;
               end else if (&gate_q) begin
                  state_q    <= ISOLATED;
                  isolated_q <= 1'b1;
               end else begin
                  gate_q <= gate_q | idle | dst_ready_i;
               end
            end
            ISOLATED: begin
               if (!isolate_i) begin
                  state_q    <= RUN;
                  gate_q     <= '0;
                  isolated_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= RUN;
               gate_q     <= '0;
               isolated_q <= 1'b0;
            end
         endcase
      end
   end

   assign isolated_o = isolated_q;

endmodule

// File: tb/tb_cdc_gray_dst_array.sv
// Randomized and directed bench for cdc_gray_dst_array. Instance 0 uses the output
// register, instance 1 is fall-through. The reference model is a per-channel write
// history plus handshake counters; every accepted beat must match the next written item.
module tb_cdc_gray_dst_array;

   localparam int NC   = 2;
   localparam int DEP  = 4;
   localparam int PW   = 3;
   localparam int DW   = 32;
   localparam int HIST = 256;

   logic clk = 1'b0;
   logic rst;

   logic [NC*DEP*DW-1:0] adata    [2];
   logic [NC*PW-1:0]     wptr     [2];
   logic [NC*PW-1:0]     rptr     [2];
   logic [NC*DW-1:0]     dout     [2];
   logic [NC-1:0]        valid    [2];
   logic [NC-1:0]        ready    [2];
   logic [NC*PW-1:0]     level    [2];
   logic                 iso      [2];
   logic                 isolated [2];
   logic [NC-1:0]        ovf      [2];

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b1;

   int            wtot      [2][NC];
   int            hs        [2][NC];
   logic [DW-1:0] hist      [2][NC][HIST];
   logic          prev_pend [2][NC];
   logic [DW-1:0] prev_data [2][NC];
   logic [PW-1:0] prev_rptr [2][NC];

   logic          mon_v;
   logic          mon_r;
   logic [DW-1:0] mon_d;
   logic [PW-1:0] mon_rp;

   always #5 clk = ~clk;

   cdc_gray_dst_array #(
      .NumChan (NC), .DataWidth (DW), .LogDepth (2), .SyncStages (2), .OutReg (1)
   ) dut (
      .dst_clk_i (clk), .dst_rst_i (rst), .async_data_i (adata[0]),
      .async_wptr_i (wptr[0]), .async_rptr_o (rptr[0]), .dst_data_o (dout[0]),
      .dst_valid_o (valid[0]), .dst_ready_i (ready[0]), .level_o (level[0]),
      .isolate_i (iso[0]), .isolated_o (isolated[0]), .ovf_err_o (ovf[0])
   );

   cdc_gray_dst_array #(
      .NumChan (NC), .DataWidth (DW), .LogDepth (2), .SyncStages (2), .OutReg (0)
   ) dut_ft (
      .dst_clk_i (clk), .dst_rst_i (rst), .async_data_i (adata[1]),
      .async_wptr_i (wptr[1]), .async_rptr_o (rptr[1]), .dst_data_o (dout[1]),
      .dst_valid_o (valid[1]), .dst_ready_i (ready[1]), .level_o (level[1]),
      .isolate_i (iso[1]), .isolated_o (isolated[1]), .ovf_err_o (ovf[1])
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] gray(input int n);
      logic [PW-1:0] b;
      b = PW'(n % 8);
      return b ^ (b >> 1);
   endfunction

   // Source side: write storage slot, record the item, advance the gray pointer.
   task automatic push(input int i, input int c, input logic [DW-1:0] d);
      int slot;
      slot = wtot[i][c] % DEP;
      adata[i][(c*DEP+slot)*DW +: DW] = d;
      hist[i][c][wtot[i][c] % HIST] = d;
      wtot[i][c]++;
      wptr[i][c*PW +: PW] = gray(wtot[i][c]);
   endtask

   task automatic wait_valid(input int i, input int c, input int max, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!valid[i][c] && n < max);
   endtask

   task automatic drain(input int i, input int max);
      int n;
      bit done;
      n = 0;
      ready[i] = '1;
      do begin
         @(posedge clk); #1;
         n++;
         done = 1'b1;
         for (int c = 0; c < NC; c++) if (hs[i][c] != wtot[i][c]) done = 1'b0;
      end while (!done && n < max);
      ready[i] = '0;
      for (int c = 0; c < NC; c++) check_eq("drain_count", hs[i][c], wtot[i][c]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         iso[i]   = 1'b0;
         ready[i] = '0;
         wptr[i]  = '0;
         adata[i] = '0;
         for (int c = 0; c < NC; c++) wtot[i][c] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Scoreboard: order/content of accepted beats, hold-until-ready, 1-bit gray steps.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < NC; c++) begin
            if (rst) begin
               hs[i][c]        = 0;
               prev_pend[i][c] = 1'b0;
               prev_rptr[i][c] = '0;
            end else if (mon_en) begin
               mon_v  = valid[i][c];
               mon_r  = ready[i][c];
               mon_d  = dout[i][c*DW +: DW];
               mon_rp = rptr[i][c*PW +: PW];
               if (prev_pend[i][c]) begin
                  check_eq("hold_valid", mon_v, 1'b1);
                  check_eq("hold_data", mon_d, prev_data[i][c]);
               end
               if (mon_v && mon_r) begin
                  if (hs[i][c] >= wtot[i][c]) check_eq("pop_beyond_writes", hs[i][c] + 1, wtot[i][c]);
                  else check_eq("pop_data", mon_d, hist[i][c][hs[i][c] % HIST]);
                  hs[i][c]++;
               end
               if (mon_rp != prev_rptr[i][c])
                  check_eq("rptr_gray_step", $countones(mon_rp ^ prev_rptr[i][c]), 1);
               prev_rptr[i][c] = mon_rp;
               prev_pend[i][c] = mon_v && !mon_r;
               prev_data[i][c] = mon_d;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hs0;
      int pushed [2][NC];
      bit done;

      do_reset();

      // Reset state of both instances.
      for (int i = 0; i < 2; i++) begin
         check_eq("rst_valid", valid[i], '0);
         check_eq("rst_isolated", isolated[i], 1'b0);
         check_eq("rst_ovf", ovf[i], '0);
         check_eq("rst_rptr", rptr[i], '0);
         check_eq("rst_level", level[i], '0);
      end
      check_eq("rst_data_reg", dout[0], '0);

      // Fall-through: valid two cycles after the pointer edge, data straight from storage.
      @(posedge clk); #1;
      push(1, 1, $urandom);
      wait_valid(1, 1, 8, n);
      check_eq("ft_latency", n, 2);
      check_eq("ft_data", dout[1][DW +: DW], hist[1][1][0]);
      drain(1, 20);

      // Registered output: first valid three cycles after the pointer edge.
      @(posedge clk); #1;
      push(0, 0, $urandom);
      wait_valid(0, 0, 8, n);
      check_eq("reg_latency", n, 3);
      for (int k = 0; k < 3; k++) begin
         push(0, 0, $urandom);
         @(posedge clk); #1;
      end
      repeat (3) @(posedge clk);
      #1;
      check_eq("level_excl_reg", level[0][PW-1:0], 3);
      drain(0, 30);
      check_eq("rptr_after_4", rptr[0][PW-1:0], 3'd6);
      check_eq("level_empty", level[0][PW-1:0], 0);
      check_eq("valid_empty", valid[0][0], 1'b0);

      // Backpressure with storage exactly full behind a loaded output register.
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         push(0, 0, $urandom);
      end
      repeat (10) @(posedge clk);
      #1;
      check_eq("level_full", level[0][PW-1:0], 4);
      check_eq("valid_held", valid[0][0], 1'b1);
      check_eq("ovf_at_full", ovf[0][0], 1'b0);
      hs0 = hs[0][0];
      for (int k = 0; k < 6; k++) begin
         ready[0][0] = (k % 2 == 0);
         @(posedge clk); #1;
      end
      ready[0][0] = 1'b0;
      check_eq("toggle_pops", hs[0][0], hs0 + 3);
      drain(0, 30);

      // Random streams on every channel of both instances; pointers wrap repeatedly.
      for (int i = 0; i < 2; i++) for (int c = 0; c < NC; c++) pushed[i][c] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         done = 1'b1;
         for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < NC; c++) begin
               ready[i][c] = 1'($urandom_range(0, 1));
               if (pushed[i][c] < 20 && (wtot[i][c] - hs[i][c]) < DEP && $urandom_range(0, 1) == 1) begin
                  push(i, c, $urandom);
                  pushed[i][c]++;
               end
               if (pushed[i][c] < 20 || hs[i][c] != wtot[i][c]) done = 1'b0;
            end
         end
         if (done) break;
      end
      for (int i = 0; i < 2; i++) begin
         ready[i] = '0;
         check_eq("stream_ovf", ovf[i], '0);
         for (int c = 0; c < NC; c++) begin
            check_eq("stream_all_popped", hs[i][c], wtot[i][c]);
            check_eq("stream_rptr", rptr[i][c*PW +: PW], gray(wtot[i][c]));
         end
      end

      // Isolation with a pending beat on ch1.
      @(posedge clk); #1;
      push(0, 1, $urandom);
      @(posedge clk); #1;
      push(0, 1, $urandom);
      wait_valid(0, 1, 8, n);
      repeat (3) @(posedge clk);
      #1;
      iso[0] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_eq("iso_hold_valid", valid[0][1], 1'b1);
      check_eq("iso_not_yet", isolated[0], 1'b0);
      ready[0][1] = 1'b1;
      @(posedge clk); #1;
      ready[0][1] = 1'b0;
      check_eq("iso_after_hs", isolated[0], 1'b0);
      check_eq("iso_no_reload", valid[0][1], 1'b0);
      @(posedge clk); #1;
      check_eq("iso_rise", isolated[0], 1'b1);
      check_eq("iso_keep_entry", level[0][PW +: PW], 1);
      push(0, 0, $urandom);
      repeat (4) @(posedge clk);
      #1;
      check_eq("iso_level_tracks", level[0][PW-1:0], 1);
      check_eq("iso_no_delivery", valid[0], '0);
      check_eq("iso_stays", isolated[0], 1'b1);
      iso[0] = 1'b0;
      wait_valid(0, 1, 4, n);
      check_eq("iso_resume", (n <= 2), 1'b1);
      check_eq("iso_released", isolated[0], 1'b0);
      drain(0, 30);

      // Corrupted pointer: sticky error until reset; reset mid-stream clears outputs.
      mon_en = 1'b0;
      do_reset();
      wptr[0][PW-1:0] = gray(7);
      repeat (4) @(posedge clk);
      #1;
      check_eq("ovf_set", ovf[0], 2'b01);
      ready[0] = '1;
      repeat (5) @(posedge clk);
      #1;
      check_eq("ovf_sticky", ovf[0], 2'b01);
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("midrst_valid", valid[0], '0);
      check_eq("midrst_ovf", ovf[0], '0);
      check_eq("midrst_rptr", rptr[0], '0);
      check_eq("midrst_level", level[0], '0);
      check_eq("midrst_isolated", isolated[0], 1'b0);
      do_reset();
      mon_en = 1'b1;

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
